// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Single-outstanding instruction fetcher with a one-entry instruction
//   buffer and branch/jump redirect handling.
//
//   Only one memory request is ever in flight. A fetched word is captured
//   into a holding buffer and offered to the decoder. The next fetch is
//   issued only after the decoder takes that word, or after a redirect
//   discards it.
//
// Parameters
//   RESET_PC        fetch address used after reset
//
// Ports
//   clk             clock; all state changes on the rising edge
//   rst             asynchronous, active-high reset
//   imem_req        memory request; stays high until imem_ack
//   imem_addr       word-aligned request address; stable while imem_req
//   imem_ack        memory response strobe; imem_rdata valid in same cycle
//   imem_rdata      returned instruction word
//   redirect_valid  taken branch/jump; redirect_pc is the new target
//   redirect_pc     redirect target; low two bits are ignored
//   instr_valid     instr/opcode/instr_pc hold a deliverable instruction
//   instr_ready     decoder accepts the instruction this cycle
//   instr           buffered instruction word
//   opcode          instr[31:26]
//   instr_pc        address of the buffered instruction
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc
);

  // IDLE  : one-cycle start-up state after reset
  // FETCH : request outstanding, its data is wanted
  // HOLD  : buffered instruction waiting for the decoder
  // FLUSH : request outstanding, but a redirect has made its data stale
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [31:0] pc_q,       pc_d;        // next sequential fetch address
  logic [31:0] req_addr_q, req_addr_d;  // address of the current request
  logic [31:0] instr_q,    instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  // Redirect targets are forced word-aligned. Masking, rather than slicing,
  // keeps every bit of redirect_pc in use.
  logic [31:0] target;
  assign target = redirect_pc & 32'hFFFF_FFFC;

  // Requests are a pure function of state. Reset therefore drops imem_req
  // in the same cycle it is asserted, with no wait for a clock edge.
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_FLUSH);
  assign imem_addr = req_addr_q;

  // A redirect kills the buffered instruction in the same cycle. The
  // decoder must not see it as valid, even though HOLD is only left on
  // the next edge.
  assign instr_valid = (state_q == S_HOLD) && !redirect_valid;

  assign instr    = instr_q;
  assign instr_pc = instr_pc_q;
  assign opcode   = instr_q[31:26];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      S_IDLE: begin
        // Any stray imem_ack here belongs to a request cancelled by reset
        // and is ignored.
        state_d = S_FETCH;
        if (redirect_valid) begin
          pc_d       = target;
          req_addr_d = target;
        end else begin
          req_addr_d = pc_q;
        end
      end

      S_FETCH: begin
        if (redirect_valid) begin
          pc_d = target;
          if (imem_ack) begin
            // The response has just retired, so the target can be
            // requested at once. The returned word is dropped.
            req_addr_d = target;
            state_d    = S_FETCH;
          end else begin
            // A request cannot be withdrawn. Let it complete in FLUSH at
            // the old address, then discard its data.
            state_d = S_FLUSH;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = req_addr_q;
          pc_d       = req_addr_q + 32'd4;  // wraps modulo 2^32
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          // Redirect takes priority over a transfer in the same cycle.
          pc_d       = target;
          req_addr_d = target;
          state_d    = S_FETCH;
        end else if (instr_ready) begin
          req_addr_d = pc_q;
          state_d    = S_FETCH;
        end
      end

      S_FLUSH: begin
        // The latest redirect wins. A redirect arriving together with the
        // stale ack is used directly as the next request address.
        if (redirect_valid) pc_d = target;
        if (imem_ack) begin
          req_addr_d = redirect_valid ? target : pc_q;
          state_d    = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic [5:0]  opcode;

  // A second instance that starts at the top of the address space. Memory
  // acks every request at once and the decoder is always ready.
  logic        req2, valid2, ack2;
  logic [31:0] addr2, instr2, ipc2;
  logic [5:0]  op2;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
  );

  assign ack2 = req2;

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(32'h1234_5678),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(valid2), .instr_ready(1'b1),
    .instr(instr2), .opcode(op2), .instr_pc(ipc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  // Reference model for the random phase. It works at the transaction
  // level: what the next new request must target, which request is
  // outstanding and whether its data is still wanted, and which captured
  // word the decoder is owed.
  logic        m_first, m_pending, m_live, m_stale;
  logic [31:0] m_expect, m_live_addr, m_paddr, m_pdata;

  initial begin
    //          redir rpc          ack rdata         rdy  req addr         vld pc           instr
    vecs[0]  = '{0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        0, 32'h0,        32'h0};
    vecs[1]  = '{0, 32'h0,        1, 32'h0400_0011, 0,   1, 32'h0,        0, 32'h0,        32'h0};
    vecs[2]  = '{0, 32'h0,        0, 32'h0,         1,   0, 32'h0,        1, 32'h0,        32'h0400_0011};
    vecs[3]  = '{0, 32'h0,        1, 32'h0800_0022, 0,   1, 32'h4,        0, 32'h0,        32'h0};
    vecs[4]  = '{0, 32'h0,        0, 32'h0,         1,   0, 32'h0,        1, 32'h4,        32'h0800_0022};
    vecs[5]  = '{0, 32'h0,        1, 32'h0C00_0033, 0,   1, 32'h8,        0, 32'h0,        32'h0};
    vecs[6]  = '{0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h0C00_0033};
    vecs[7]  = '{0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h0C00_0033};
    vecs[8]  = '{0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h0C00_0033};
    vecs[9]  = '{0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h0C00_0033};
    vecs[10] = '{0, 32'h0,        0, 32'h0,         0,   0, 32'h0,        1, 32'h8,        32'h0C00_0033};
    vecs[11] = '{0, 32'h0,        0, 32'h0,         1,   0, 32'h0,        1, 32'h8,        32'h0C00_0033};
    vecs[12] = '{1, 32'h0000_0103, 0, 32'h0,        0,   1, 32'hC,        0, 32'h0,        32'h0};
    vecs[13] = '{0, 32'h0,        0, 32'h0,         0,   1, 32'hC,        0, 32'h0,        32'h0};
    vecs[14] = '{0, 32'h0,        0, 32'h0,         0,   1, 32'hC,        0, 32'h0,        32'h0};
    vecs[15] = '{0, 32'h0,        1, 32'hDEAD_BEEF, 0,   1, 32'hC,        0, 32'h0,        32'h0};
    vecs[16] = '{0, 32'h0,        1, 32'h1000_0044, 0,   1, 32'h100,      0, 32'h0,        32'h0};
    vecs[17] = '{1, 32'h0000_0200, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0};
    vecs[18] = '{0, 32'h0,        0, 32'h0,         0,   1, 32'h200,      0, 32'h0,        32'h0};
    vecs[19] = '{1, 32'h0000_0302, 1, 32'hBAD0_BAD0, 0,  1, 32'h200,      0, 32'h0,        32'h0};
    vecs[20] = '{0, 32'h0,        1, 32'h1400_0055, 0,   1, 32'h300,      0, 32'h0,        32'h0};
    vecs[21] = '{0, 32'h0,        0, 32'h0,         1,   0, 32'h0,        1, 32'h300,      32'h1400_0055};
    vecs[22] = '{1, 32'h0000_0400, 0, 32'h0,        0,   1, 32'h304,      0, 32'h0,        32'h0};
    vecs[23] = '{1, 32'h0000_0500, 0, 32'h0,        0,   1, 32'h304,      0, 32'h0,        32'h0};
    vecs[24] = '{1, 32'h0000_0601, 1, 32'hBAD1_BAD1, 0,  1, 32'h304,      0, 32'h0,        32'h0};
    vecs[25] = '{0, 32'h0,        0, 32'h0,         0,   1, 32'h600,      0, 32'h0,        32'h0};

    rst = 1'b1; imem_ack = 0; imem_rdata = 0; redirect_valid = 0;
    redirect_pc = 0; instr_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst imem_req",    {31'b0, imem_req},    32'h0);
    chk("rst instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst imem_addr",   imem_addr,            32'h0);
    chk("rst instr",       instr,                32'h0);
    chk("rst instr_pc",    instr_pc,             32'h0);
    chk("rst opcode",      {26'b0, opcode},      32'h0);
    chk("rst2 imem_addr",  addr2,                32'hFFFF_FFFC);

    // Directed table, one row per clock cycle.
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      instr_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d imem_req", i),    {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      chk($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_req)
        chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d instr", i),    instr,    vecs[i].e_instr);
        chk($sformatf("vec%0d opcode", i),   {26'b0, opcode}, {26'b0, vecs[i].e_instr[31:26]});
      end
      if (i == 1) chk("wrap first addr",  addr2, 32'hFFFF_FFFC);
      if (i == 3) chk("wrap second addr", addr2, 32'h0000_0000);
      @(posedge clk); #1;
    end

    // Reset in the middle of a request, with a late ack still present
    // when reset is released.
    redirect_valid = 0; imem_ack = 0; instr_ready = 0;
    #2 rst = 1'b1;
    #1 chk("midrst imem_req", {31'b0, imem_req}, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("late ack idle req", {31'b0, imem_req}, 32'h0);
    @(posedge clk); #1 imem_ack = 1'b1; imem_rdata = 32'h2000_0066;
    @(negedge clk);
    chk("restart req",  {31'b0, imem_req}, 32'h1);
    chk("restart addr", imem_addr, 32'h0);
    @(posedge clk); #1 imem_ack = 1'b0;
    @(negedge clk);
    chk("restart valid", {31'b0, instr_valid}, 32'h1);
    chk("restart instr", instr, 32'h2000_0066);
    chk("restart pc",    instr_pc, 32'h0);

    // Random stimulus checked against the reference model.
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_first = 1; m_pending = 0; m_live = 0; m_stale = 0;
    m_expect = 32'h0; m_live_addr = 0; m_paddr = 0; m_pdata = 0;
    for (int c = 0; c < 3000; c++) begin
      logic exp_req, old_pending;
      redirect_valid = ($urandom_range(7) == 0);
      redirect_pc    = $urandom;
      imem_ack       = imem_req && ($urandom_range(1) == 1);
      imem_rdata     = $urandom;
      instr_ready    = ($urandom_range(1) == 1);
      @(negedge clk);
      exp_req = !m_first && !m_pending;
      chk("rnd imem_req",    {31'b0, imem_req},    {31'b0, exp_req});
      chk("rnd instr_valid", {31'b0, instr_valid}, {31'b0, m_pending && !redirect_valid});
      if (m_pending) begin
        chk("rnd instr_pc", instr_pc, m_paddr);
        chk("rnd instr",    instr,    m_pdata);
        chk("rnd opcode",   {26'b0, opcode}, {26'b0, m_pdata[31:26]});
      end
      if (exp_req)
        chk("rnd imem_addr", imem_addr, m_live ? m_live_addr : m_expect);
      // The model takes the effect of this cycle's edge.
      if (exp_req && !m_live) begin
        m_live = 1; m_live_addr = m_expect; m_stale = 0;
      end
      m_first = 0;
      old_pending = m_pending;
      if (old_pending && instr_ready && !redirect_valid) m_pending = 0;
      if (m_live && imem_ack) begin
        m_live = 0;
        if (!m_stale && !redirect_valid) begin
          m_pending = 1; m_paddr = m_live_addr; m_pdata = imem_rdata;
          m_expect = m_live_addr + 32'd4;
        end
      end
      if (redirect_valid) begin
        m_expect = redirect_pc & 32'hFFFF_FFFC;
        m_pending = 0;
        if (m_live) m_stale = 1;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
